oisc_mem_responder: RTL and testbench

- Memory-side responder for the OISC processor's SRAM request interface: services sram_en/sram_we/address/write-data requests from the processor control path and returns read data.
- Owns the program/data memory array and a host load port that fills memory while the processor is held in reset.
- Releases the processor into run, detects the halt store, and re-freezes the processor.

---
 rtl/oisc_mem_responder.sv | 134 +++++++++++++
 tb/tb_oisc_mem_responder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/oisc_mem_responder.sv
// OISC SRAM responder: host-loaded memory, run/halt control; reads return 1 cycle after request,
// ld_ready backpressures the host outside LOAD. Optional write protection: OISC_MEM_WPROT_EN.
module oisc_mem_responder #(
  parameter int unsigned    AW        = 8,
  parameter int unsigned    DW        = 8,
  parameter logic [AW-1:0]  HALT_ADDR = {AW{1'b1}}
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic          start,
  input  logic          clr,
  output logic          cpu_rstn,
  input  logic          sram_en,
  input  logic          sram_we,
  input  logic [AW-1:0] sram_addr,
  input  logic [DW-1:0] sram_wdata,
  output logic [DW-1:0] sram_rdata,
  output logic          halted,
  output logic [DW-1:0] halt_code,
  output logic          err
);

  localparam int unsigned DEPTH = 2 ** AW;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic [DW-1:0] mem [DEPTH];

  logic          ld_fire;
  logic          cpu_rd;
  logic          cpu_wr;
  logic          halt_wr;
  logic          wr_allowed;
  logic          wr_blocked;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;

`ifdef OISC_MEM_WPROT_EN
  // Lower half of the space is code; only the halt store may land there.
  assign wr_allowed = sram_addr[AW-1] || (sram_addr == HALT_ADDR);
`else
  assign wr_allowed = 1'b1;
`endif
  assign wr_blocked = !wr_allowed;

  assign ld_fire = (state == ST_LOAD) && ld_valid && ld_ready;
  assign cpu_rd  = (state == ST_RUN) && sram_en && !sram_we;
  assign cpu_wr  = (state == ST_RUN) && sram_en && sram_we;
  assign halt_wr = cpu_wr && (sram_addr == HALT_ADDR);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_LOAD: if (start)   state_nxt = ST_RUN;
      ST_RUN:  if (halt_wr) state_nxt = ST_HALT;
      ST_HALT: if (clr)     state_nxt = ST_LOAD;
      default:              state_nxt = ST_LOAD;
    endcase
  end

  // Host and processor never share a cycle, so one write port suffices.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = ld_addr;
    mem_wdata = ld_data;
    if (ld_fire) begin
      mem_we = 1'b1;
    end else if (cpu_wr && wr_allowed) begin
      mem_we    = 1'b1;
      mem_waddr = sram_addr;
      mem_wdata = sram_wdata;
    end
  end

  // Memory contents are deliberately not reset so a program survives rstn.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_LOAD;
      cpu_rstn   <= 1'b0;
      ld_ready   <= 1'b0;
      halted     <= 1'b0;
      sram_rdata <= '0;
      halt_code  <= '0;
    end else begin
      state    <= state_nxt;
      cpu_rstn <= (state_nxt == ST_RUN);
      ld_ready <= (state_nxt == ST_LOAD);
      halted   <= (state_nxt == ST_HALT);
      if (cpu_rd) begin
        sram_rdata <= mem[sram_addr];
      end
      if (halt_wr) begin
        halt_code <= sram_wdata;
      end
    end
  end

`ifdef OISC_MEM_WPROT_EN
  logic err_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_q <= 1'b0;
    end else if ((state == ST_HALT) && clr) begin
      err_q <= 1'b0;
    end else if (cpu_wr && wr_blocked) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0 & wr_blocked;
`endif

endmodule

// File: tb/tb_oisc_mem_responder.sv
// Directed bench for oisc_mem_responder with a read-data scoreboard queue.
module tb_oisc_mem_responder;

  logic       clk;
  logic       rstn;
  logic       ld_valid;
  logic       ld_ready;
  logic [7:0] ld_addr;
  logic [7:0] ld_data;
  logic       start;
  logic       clr;
  logic       cpu_rstn;
  logic       sram_en;
  logic       sram_we;
  logic [7:0] sram_addr;
  logic [7:0] sram_wdata;
  logic [7:0] sram_rdata;
  logic       halted;
  logic [7:0] halt_code;
  logic       err;

  int         tests;
  int         fails;
  logic [7:0] model [256];
  logic [7:0] exp_q [$];
  logic [7:0] exp_10;
  logic       exp_err;

  oisc_mem_responder #(.AW(8), .DW(8), .HALT_ADDR(8'hFF)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .start      (start),
    .clr        (clr),
    .cpu_rstn   (cpu_rstn),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .halted     (halted),
    .halt_code  (halt_code),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic load_beat(input logic [7:0] a, input logic [7:0] d, input logic with_start);
    ld_valid = 1'b1;
    ld_addr  = a;
    ld_data  = d;
    start    = with_start;
    model[a] = d;
    step();
    ld_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
    logic allowed;
    allowed = 1'b1;
`ifdef OISC_MEM_WPROT_EN
    if (!a[7] && a != 8'hFF) allowed = 1'b0;
`endif
    if (allowed) model[a] = d;
    sram_en    = 1'b1;
    sram_we    = 1'b1;
    sram_addr  = a;
    sram_wdata = d;
    step();
    sram_en = 1'b0;
    sram_we = 1'b0;
  endtask

  task automatic cpu_read(input string tag, input logic [7:0] a);
    logic [7:0] e;
    exp_q.push_back(model[a]);
    sram_en   = 1'b1;
    sram_we   = 1'b0;
    sram_addr = a;
    step();
    sram_en = 1'b0;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s: scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      chk8(tag, sram_rdata, e);
    end
  endtask

  initial begin
    tests      = 0;
    fails      = 0;
    rstn       = 1'b0;
    ld_valid   = 1'b0;
    ld_addr    = 8'h00;
    ld_data    = 8'h00;
    start      = 1'b0;
    clr        = 1'b0;
    sram_en    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = 8'h00;
    sram_wdata = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    chk1("rst_cpu_rstn", cpu_rstn, 1'b0);
    chk1("rst_ld_ready", ld_ready, 1'b0);
    chk8("rst_rdata", sram_rdata, 8'h00);
    chk1("rst_halted", halted, 1'b0);
    chk8("rst_halt_code", halt_code, 8'h00);
    chk1("rst_err", err, 1'b0);

    rstn = 1'b1;
    step();
    chk1("ld_ready_first_edge", ld_ready, 1'b1);
    chk1("load_cpu_rstn", cpu_rstn, 1'b0);

    load_beat(8'h00, 8'h11, 1'b0);
    load_beat(8'h01, 8'h22, 1'b0);
    load_beat(8'h03, 8'h44, 1'b0);
    load_beat(8'h10, 8'h5A, 1'b0);
    chk1("load_cpu_rstn_held", cpu_rstn, 1'b0);
    chk1("load_ld_ready_held", ld_ready, 1'b1);
    // Beat coincident with start is still written.
    load_beat(8'h02, 8'h33, 1'b1);
    chk1("run_cpu_rstn", cpu_rstn, 1'b1);
    chk1("run_ld_ready", ld_ready, 1'b0);

    // Host port ignored in RUN; start/clr ignored too.
    ld_valid = 1'b1;
    ld_addr  = 8'h03;
    ld_data  = 8'hEE;
    clr      = 1'b1;
    start    = 1'b1;
    step();
    ld_valid = 1'b0;
    clr      = 1'b0;
    start    = 1'b0;
    chk1("run_clr_ignored", cpu_rstn, 1'b1);
    chk1("run_not_halted", halted, 1'b0);

    cpu_read("rd_01", 8'h01);
    step();
    chk8("rd_hold", sram_rdata, 8'h22);
    cpu_read("rd_02_coincident", 8'h02);
    cpu_read("rd_03_ld_ignored", 8'h03);
    cpu_read("rd_00", 8'h00);

    cpu_write(8'h90, 8'hA5);
    cpu_read("wr_rd_90", 8'h90);

`ifdef OISC_MEM_WPROT_EN
    exp_10  = 8'h5A;
    exp_err = 1'b1;
`else
    exp_10  = 8'h77;
    exp_err = 1'b0;
`endif
    cpu_write(8'h10, 8'h77);
    chk1("err_after_low_write", err, exp_err);
    cpu_read("rd_10", 8'h10);
    chk8("rd_10_indep", sram_rdata, exp_10);
    chk1("err_sticky", err, exp_err);

    cpu_write(8'hFF, 8'h3C);
    chk1("halt_halted", halted, 1'b1);
    chk1("halt_cpu_rstn", cpu_rstn, 1'b0);
    chk8("halt_code", halt_code, 8'h3C);
    chk1("halt_ld_ready", ld_ready, 1'b0);

    // Processor port and start are ignored in HALT.
    sram_en    = 1'b1;
    sram_we    = 1'b1;
    sram_addr  = 8'h90;
    sram_wdata = 8'h00;
    start      = 1'b1;
    step();
    sram_we = 1'b0;
    sram_addr = 8'h00;
    step();
    sram_en = 1'b0;
    start   = 1'b0;
    chk8("halt_rd_ignored", sram_rdata, exp_10);
    chk1("halt_start_ignored", halted, 1'b1);

    clr = 1'b1;
    step();
    clr = 1'b0;
    chk1("clr_halted", halted, 1'b0);
    chk1("clr_ld_ready", ld_ready, 1'b1);
    chk8("clr_halt_code_held", halt_code, 8'h3C);
    chk1("clr_err", err, 1'b0);

    start = 1'b1;
    step();
    start = 1'b0;
    chk1("rerun_cpu_rstn", cpu_rstn, 1'b1);
    cpu_read("rd_ff_retained", 8'hFF);
    cpu_read("rd_90_halt_wr_ignored", 8'h90);

    // Asynchronous reset between edges in RUN.
    #2;
    rstn = 1'b0;
    #1;
    chk1("async_cpu_rstn", cpu_rstn, 1'b0);
    chk8("async_rdata", sram_rdata, 8'h00);
    chk8("async_halt_code", halt_code, 8'h00);
    #3;
    rstn = 1'b1;
    step();
    chk1("post_rst_ld_ready", ld_ready, 1'b1);
    chk1("post_rst_cpu_rstn", cpu_rstn, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk1("restart_cpu_rstn", cpu_rstn, 1'b1);
    cpu_read("rd_00_after_reset", 8'h00);
    cpu_read("rd_01_after_reset", 8'h01);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
